fir_sample_feeder: RTL and testbench

Upstream sequencer for the 128-tap serial FIR stage. It accepts raw samples on a strobe-only input stream with no backpressure and buffers them in a small FIFO. For each sample it holds the value on `fir_sig` and asserts `fir_ready` for exactly `FRAME_LEN` consecutive cycles, which is one full multiply-accumulate pass of the downstream filter. It then pulses `frame_done` to mark that the filter output has been refreshed.

---
 rtl/fir_sample_feeder.sv | 147 ++++++++++++++
 tb/tb_fir_sample_feeder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered sequencer that holds each sample for one full FIR pass.
// Optional macro FEEDER_DROP_CNT_EN adds a saturating 16-bit drop counter output (drop_cnt).
module fir_sample_feeder #(
   parameter int WIDTH      = 18,
   parameter int FRAME_LEN  = 128,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WIDTH-1:0]              s_data,
   input  logic                          s_valid,
   output logic [WIDTH-1:0]              fir_sig,
   output logic                          fir_ready,
   output logic                          frame_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
`ifdef FEEDER_DROP_CNT_EN
   ,
   output logic [15:0]                   drop_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} StateT;

   StateT            r_state;
   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [LVL_W-1:0] r_level;
   logic [CNT_W-1:0] r_frameCnt;
   logic [WIDTH-1:0] r_firSig;
   logic             r_firReady;
   logic             r_frameDone;
   logic             r_overflow;

   logic w_empty;
   logic w_full;
   logic w_endFrame;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // A pop frees a slot in the same cycle, so a push into a full FIFO survives only then.
   assign w_empty    = (r_level == '0);
   assign w_full     = (r_level == FULL_LVL);
   assign w_endFrame = (r_state == RUN) && (r_frameCnt == LAST_CNT);
   assign w_pop      = !w_empty && ((r_state == IDLE) || w_endFrame);
   assign w_push     = s_valid && (!w_full || w_pop);
   assign w_drop     = s_valid && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_pop && !w_push) begin
            r_level <= r_level - LVL_W'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // fir_sig only changes on a pop, so it stays stable through the last frame cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_frameCnt  <= '0;
         r_firSig    <= '0;
         r_firReady  <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= w_endFrame;
         if (w_pop) begin
            r_firSig <= r_mem[r_rdPtr];
         end
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_state    <= RUN;
                  r_firReady <= 1'b1;
                  r_frameCnt <= '0;
               end
            end
            RUN: begin
               if (w_endFrame) begin
                  r_frameCnt <= '0;
                  if (!w_pop) begin
                     r_state    <= IDLE;
                     r_firReady <= 1'b0;
                  end
               end else begin
                  r_frameCnt <= r_frameCnt + CNT_W'(1);
               end
            end
            default: begin
               r_state    <= IDLE;
               r_firReady <= 1'b0;
            end
         endcase
      end
   end

`ifdef FEEDER_DROP_CNT_EN
   logic [15:0] r_dropCnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCnt <= '0;
      end else if (w_drop && (r_dropCnt != 16'hFFFF)) begin
         r_dropCnt <= r_dropCnt + 16'd1;
      end
   end

   assign drop_cnt = r_dropCnt;
`endif

   assign fir_sig    = r_firSig;
   assign fir_ready  = r_firReady;
   assign frame_done = r_frameDone;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed timing checks plus randomized traffic against a queue-based model.
// Build with FEEDER_DROP_CNT_EN defined to also exercise drop_cnt.
module tb_fir_sample_feeder;

   localparam int WIDTH      = 18;
   localparam int FRAME_LEN  = 128;
   localparam int FIFO_DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] s_data;
   logic             s_valid;
   logic [WIDTH-1:0] fir_sig;
   logic             fir_ready;
   logic             frame_done;
   logic [3:0]       fifo_level;
   logic             overflow;
`ifdef FEEDER_DROP_CNT_EN
   logic [15:0]      drop_cnt;
`endif

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: the FIFO is a queue, a frame is "remaining cycles" of fir_ready.
   logic [WIDTH-1:0] mQ[$];
   logic [WIDTH-1:0] mSig;
   bit               mReady;
   bit               mDone;
   bit               mOvf;
   int               mRemain;
   int               mDrops;

   fir_sample_feeder #(
      .WIDTH(WIDTH),
      .FRAME_LEN(FRAME_LEN),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_data(s_data),
      .s_valid(s_valid),
      .fir_sig(fir_sig),
      .fir_ready(fir_ready),
      .frame_done(frame_done),
      .fifo_level(fifo_level),
      .overflow(overflow)
`ifdef FEEDER_DROP_CNT_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic modelStep();
      bit endFrame;
      bit popNow;
      int sz;
      if (rst) begin
         mQ.delete();
         mSig = '0; mReady = 0; mDone = 0; mOvf = 0; mRemain = 0; mDrops = 0;
         return;
      end
      sz       = mQ.size();
      endFrame = mReady && (mRemain == 1);
      popNow   = (sz > 0) && (!mReady || endFrame);
      mDone    = endFrame;
      if (popNow) begin
         mSig    = mQ.pop_front();
         mReady  = 1;
         mRemain = FRAME_LEN;
      end else if (endFrame) begin
         mReady  = 0;
         mRemain = 0;
      end else if (mReady) begin
         mRemain--;
      end
      if (s_valid) begin
         if (sz < FIFO_DEPTH || popNow) begin
            mQ.push_back(s_data);
         end else begin
            mOvf = 1;
            if (mDrops < 65535) mDrops++;
         end
      end
   endtask

   // Drives one cycle of input from a negedge, advances the model at the posedge.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
      s_valid = v;
      s_data  = d;
      @(posedge clk);
      modelStep();
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      applyStimulus(1'b0, '0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(1'b1, 18'h3FFFF);
      applyStimulus(1'b0, '0);
      rst = 1'b0;
      nChecks += 5;
      if (fir_sig !== '0) begin nErrors++; $display("[TB] FAIL reset_sig got %h exp 0", fir_sig); end
      if (fir_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_ready got %b exp 0", fir_ready); end
      if (frame_done !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_done got %b exp 0", frame_done); end
      if (fifo_level !== 4'd0) begin nErrors++; $display("[TB] FAIL reset_level got %0d exp 0", fifo_level); end
      if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_ovf got %b exp 0", overflow); end
`ifdef FEEDER_DROP_CNT_EN
      nChecks++;
      if (drop_cnt !== 16'd0) begin nErrors++; $display("[TB] FAIL reset_drop got %0d exp 0", drop_cnt); end
`endif
   endtask

   task automatic test_single();
      int readyCnt = 0;
      for (int c = 0; c <= 140; c++) begin
         if (c > 0) begin
            nChecks += 3;
            if (fir_ready !== (c >= 2 && c <= 129)) begin
               nErrors++; $display("[TB] FAIL single_ready c=%0d got %b", c, fir_ready);
            end
            if (frame_done !== (c == 130)) begin
               nErrors++; $display("[TB] FAIL single_done c=%0d got %b", c, frame_done);
            end
            if (fifo_level !== ((c == 1) ? 4'd1 : 4'd0)) begin
               nErrors++; $display("[TB] FAIL single_level c=%0d got %0d", c, fifo_level);
            end
            if (c >= 2 && c <= 129) begin
               nChecks++;
               if (fir_sig !== 18'h00123) begin
                  nErrors++; $display("[TB] FAIL single_sig c=%0d got %h exp 00123", c, fir_sig);
               end
            end
            if (fir_ready) readyCnt++;
         end
         applyStimulus(c == 0, 18'h00123);
      end
      nChecks++;
      if (readyCnt != FRAME_LEN) begin
         nErrors++; $display("[TB] FAIL single_len got %0d exp %0d", readyCnt, FRAME_LEN);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] vals[3];
      logic [WIDTH-1:0] expSig;
      vals[0] = 18'd5;
      vals[1] = 18'(-7);
      vals[2] = 18'd9;
      for (int c = 0; c <= 390; c++) begin
         if (c > 0) begin
            nChecks += 2;
            if (fir_ready !== (c >= 2 && c <= 385)) begin
               nErrors++; $display("[TB] FAIL b2b_ready c=%0d got %b", c, fir_ready);
            end
            if (frame_done !== (c == 130 || c == 258 || c == 386)) begin
               nErrors++; $display("[TB] FAIL b2b_done c=%0d got %b", c, frame_done);
            end
            if (c >= 2 && c <= 385) begin
               expSig = (c < 130) ? vals[0] : ((c < 258) ? vals[1] : vals[2]);
               nChecks++;
               if (fir_sig !== expSig) begin
                  nErrors++; $display("[TB] FAIL b2b_sig c=%0d got %h exp %h", c, fir_sig, expSig);
               end
            end
         end
         applyStimulus(c < 3, (c < 3) ? vals[c] : '0);
      end
   endtask

   task automatic test_overflow();
      int peak = 0;
      applyReset();
      for (int c = 0; c <= 1300; c++) begin
         if (c > 0) begin
            nChecks += 5;
            if (fir_ready !== mReady) begin nErrors++; $display("[TB] FAIL ovf_ready c=%0d got %b exp %b", c, fir_ready, mReady); end
            if (frame_done !== mDone) begin nErrors++; $display("[TB] FAIL ovf_done c=%0d got %b exp %b", c, frame_done, mDone); end
            if (fir_sig !== mSig) begin nErrors++; $display("[TB] FAIL ovf_sig c=%0d got %h exp %h", c, fir_sig, mSig); end
            if (fifo_level !== 4'(mQ.size())) begin nErrors++; $display("[TB] FAIL ovf_level c=%0d got %0d exp %0d", c, fifo_level, mQ.size()); end
            if (overflow !== mOvf) begin nErrors++; $display("[TB] FAIL ovf_flag c=%0d got %b exp %b", c, overflow, mOvf); end
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
         end
         applyStimulus(c < 10, 18'($urandom));
      end
      nChecks += 2;
      if (peak != 8) begin nErrors++; $display("[TB] FAIL ovf_peak got %0d exp 8", peak); end
      if (overflow !== 1'b1) begin nErrors++; $display("[TB] FAIL ovf_sticky got %b exp 1", overflow); end
`ifdef FEEDER_DROP_CNT_EN
      nChecks++;
      if (drop_cnt !== 16'd1) begin nErrors++; $display("[TB] FAIL ovf_dropcnt got %0d exp 1", drop_cnt); end
`endif
   endtask

   task automatic test_push_pop_full();
      applyReset();
      for (int c = 0; c <= 135; c++) begin
         if (c > 0) begin
            nChecks += 4;
            if (fir_ready !== mReady) begin nErrors++; $display("[TB] FAIL ppf_ready c=%0d got %b exp %b", c, fir_ready, mReady); end
            if (frame_done !== mDone) begin nErrors++; $display("[TB] FAIL ppf_done c=%0d got %b exp %b", c, frame_done, mDone); end
            if (fir_sig !== mSig) begin nErrors++; $display("[TB] FAIL ppf_sig c=%0d got %h exp %h", c, fir_sig, mSig); end
            if (fifo_level !== 4'(mQ.size())) begin nErrors++; $display("[TB] FAIL ppf_level c=%0d got %0d exp %0d", c, fifo_level, mQ.size()); end
         end
         if (c == 129 || c == 130) begin
            nChecks += 2;
            if (fifo_level !== 4'd8) begin nErrors++; $display("[TB] FAIL ppf_full c=%0d got %0d exp 8", c, fifo_level); end
            if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL ppf_ovf c=%0d got %b exp 0", c, overflow); end
         end
         applyStimulus((c <= 8) || (c == 129), 18'($urandom));
      end
   endtask

   task automatic test_reset_mid_frame();
      int readyCnt = 0;
      int doneCnt  = 0;
      applyReset();
      for (int c = 0; c < 52; c++) begin
         applyStimulus(c == 0 || c == 10, 18'($urandom));
      end
      rst = 1'b1;
      applyStimulus(1'b0, '0);
      rst = 1'b0;
      nChecks += 5;
      if (fir_sig !== '0) begin nErrors++; $display("[TB] FAIL rmid_sig got %h exp 0", fir_sig); end
      if (fir_ready !== 1'b0) begin nErrors++; $display("[TB] FAIL rmid_ready got %b exp 0", fir_ready); end
      if (frame_done !== 1'b0) begin nErrors++; $display("[TB] FAIL rmid_done got %b exp 0", frame_done); end
      if (fifo_level !== 4'd0) begin nErrors++; $display("[TB] FAIL rmid_level got %0d exp 0", fifo_level); end
      if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL rmid_ovf got %b exp 0", overflow); end
      for (int c = 0; c <= 260; c++) begin
         if (c > 0) begin
            nChecks += 2;
            if (fir_ready !== (c >= 2 && c <= 129)) begin
               nErrors++; $display("[TB] FAIL rmid_frame c=%0d got %b", c, fir_ready);
            end
            if (frame_done !== (c == 130)) begin
               nErrors++; $display("[TB] FAIL rmid_fdone c=%0d got %b", c, frame_done);
            end
            if (fir_ready) readyCnt++;
            if (frame_done) doneCnt++;
         end
         applyStimulus(c == 0, 18'h2A5A5);
      end
      nChecks += 2;
      if (readyCnt != FRAME_LEN) begin nErrors++; $display("[TB] FAIL rmid_len got %0d exp %0d", readyCnt, FRAME_LEN); end
      if (doneCnt != 1) begin nErrors++; $display("[TB] FAIL rmid_ndone got %0d exp 1", doneCnt); end
   endtask

   task automatic test_pointer_wrap();
      logic [WIDTH-1:0] samples[20];
      for (int k = 0; k < 20; k++) samples[k] = 18'($urandom);
      applyReset();
      for (int c = 0; c <= 20 * 130 + 5; c++) begin
         if (c > 0) begin
            nChecks += 4;
            if (fir_ready !== mReady) begin nErrors++; $display("[TB] FAIL wrap_ready c=%0d got %b exp %b", c, fir_ready, mReady); end
            if (frame_done !== mDone) begin nErrors++; $display("[TB] FAIL wrap_done c=%0d got %b exp %b", c, frame_done, mDone); end
            if (fir_sig !== mSig) begin nErrors++; $display("[TB] FAIL wrap_sig c=%0d got %h exp %h", c, fir_sig, mSig); end
            if (fifo_level !== 4'(mQ.size())) begin nErrors++; $display("[TB] FAIL wrap_level c=%0d got %0d exp %0d", c, fifo_level, mQ.size()); end
         end
         if ((c % 130) == 60 && (c / 130) < 20) begin
            nChecks++;
            if (fir_sig !== samples[c / 130]) begin
               nErrors++; $display("[TB] FAIL wrap_order k=%0d got %h exp %h", c / 130, fir_sig, samples[c / 130]);
            end
         end
         applyStimulus((c % 130) == 0 && (c / 130) < 20, samples[(c / 130) % 20]);
      end
      nChecks++;
      if (overflow !== 1'b0) begin nErrors++; $display("[TB] FAIL wrap_ovf got %b exp 0", overflow); end
   endtask

   task automatic test_random_traffic();
      applyReset();
      for (int c = 0; c <= 6400; c++) begin
         if (c > 0) begin
            nChecks += 5;
            if (fir_ready !== mReady) begin nErrors++; $display("[TB] FAIL rnd_ready c=%0d got %b exp %b", c, fir_ready, mReady); end
            if (frame_done !== mDone) begin nErrors++; $display("[TB] FAIL rnd_done c=%0d got %b exp %b", c, frame_done, mDone); end
            if (fir_sig !== mSig) begin nErrors++; $display("[TB] FAIL rnd_sig c=%0d got %h exp %h", c, fir_sig, mSig); end
            if (fifo_level !== 4'(mQ.size())) begin nErrors++; $display("[TB] FAIL rnd_level c=%0d got %0d exp %0d", c, fifo_level, mQ.size()); end
            if (overflow !== mOvf) begin nErrors++; $display("[TB] FAIL rnd_ovf c=%0d got %b exp %b", c, overflow, mOvf); end
         end
         applyStimulus((c < 5000) && ($urandom_range(0, 99) == 0), 18'($urandom));
      end
`ifdef FEEDER_DROP_CNT_EN
      nChecks++;
      if (drop_cnt !== 16'(mDrops)) begin nErrors++; $display("[TB] FAIL rnd_dropcnt got %0d exp %0d", drop_cnt, mDrops); end
`endif
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_push_pop_full();
      test_reset_mid_frame();
      test_pointer_wrap();
      test_random_traffic();
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
